// File: rtl/fwd_scoreboard_pipe.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_pipe
//
// Operand-forwarding scoreboard for the pipelined core. It keeps a shadow
// pipeline of in-flight destination tags from EX (slot 0) down to the last
// tracked write-back stage (slot DEPTH). From that shadow state it produces:
//   - a forward select for each source operand of the EX-stage instruction
//   - a load-use stall request for the ID-stage instruction
//   - a saturating count of stalled cycles
//
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   id_valid       ID holds a real instruction
//   id_dst         ID destination register
//   id_wr          ID instruction writes the register file
//   id_load        ID instruction is a load
//   id_src         ID source registers, operand i at [i*AW +: AW]
//   id_src_used    operand i is actually read
//   flush          squash ID and EX (redirect resolved in EX)
//   fwd_sel        per EX operand: 0 = regfile, k = forward from slot k
//   stall          hold PC/IF/ID this cycle, EX receives a bubble
//   stall_cnt      saturating count of cycles with stall=1
//   clr_cnt        synchronous clear of stall_cnt
// -----------------------------------------------------------------------------
module fwd_scoreboard_pipe #(
   parameter int AW         = 3,
   parameter int NSRC       = 2,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int SEL_W      = $clog2(DEPTH + 1),
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [AW-1:0]         id_dst,
   input  logic                  id_wr,
   input  logic                  id_load,
   input  logic [NSRC*AW-1:0]    id_src,
   input  logic [NSRC-1:0]       id_src_used,
   input  logic                  flush,
   output logic [NSRC*SEL_W-1:0] fwd_sel,
   output logic                  stall,
   output logic [CNT_W-1:0]      stall_cnt,
   input  logic                  clr_cnt
);

   typedef struct packed {
      logic             hit;
      logic [SEL_W-1:0] idx;
      logic             load;
   } match_t;

   // Slot 0 = EX, slots 1..DEPTH = producers behind EX.
   logic [DEPTH:0]     slot_v;
   logic [DEPTH:0]     slot_wr;
   logic [DEPTH:0]     slot_load;
   logic [AW-1:0]      slot_dst [0:DEPTH];
   logic [NSRC*AW-1:0] ex_src;
   logic [NSRC-1:0]    ex_src_used;

   logic               hazard;
   logic               bubble;
   logic               early_load_hit;
   match_t             id_m;
   match_t             ex_m;

   // Youngest (smallest index) slot in first..last that will write reg_addr.
   function automatic match_t youngest_match(input logic [AW-1:0] reg_addr,
                                             input int first, input int last);
      match_t m;
      m = '0;
      // Walk from oldest to youngest so a younger hit overwrites an older one.
      for (int k = last; k >= first; k--) begin
         if (slot_v[k] && slot_wr[k] && (slot_dst[k] == reg_addr)) begin
            m.hit  = 1'b1;
            m.idx  = SEL_W'(k);
            m.load = slot_load[k];
         end
      end
      return m;
   endfunction

   // ---------------------------------------------------------------------------
   // Load-use hazard for the ID instruction. It lands in EX next cycle, so a
   // producer now in slot j will sit in slot j+1 when the consumer needs it.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it holding its old value and no latch is inferred.
      hazard = 1'b0;
      id_m   = '0;
      for (int i = 0; i < NSRC; i++) begin
         id_m = youngest_match(id_src[i*AW +: AW], 0, DEPTH - 1);
         if (id_src_used[i] && id_m.hit && id_m.load &&
             (int'(id_m.idx) + 1 < LOAD_STAGE)) begin
            hazard = 1'b1;
         end
      end
   end

   assign stall  = id_valid & ~flush & hazard;
   assign bubble = flush | stall;

   // ---------------------------------------------------------------------------
   // Forward selects for the EX instruction. A load found closer than
   // LOAD_STAGE has no data yet; the stall logic keeps that from happening,
   // and early_load_hit flags it if it ever does.
   // ---------------------------------------------------------------------------
   always_comb begin
      fwd_sel        = '0;
      early_load_hit = 1'b0;
      ex_m           = '0;
      for (int i = 0; i < NSRC; i++) begin
         ex_m = youngest_match(ex_src[i*AW +: AW], 1, DEPTH);
         if (ex_src_used[i] && ex_m.hit) begin
            if (ex_m.load && (int'(ex_m.idx) < LOAD_STAGE)) begin
               early_load_hit = 1'b1;
            end else begin
               fwd_sel[i*SEL_W +: SEL_W] = ex_m.idx;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control state: valid bits and EX operand-used bits.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // slot samples its predecessor's pre-edge value and the shift is ordered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_v      <= '0;
         ex_src_used <= '0;
      end else begin
         for (int k = 1; k <= DEPTH; k++) begin
            slot_v[k] <= slot_v[k-1];
         end
         slot_v[0]   <= id_valid & ~bubble;
         // An invalid ID slot reads nothing, so its used bits are dropped too.
         ex_src_used <= bubble ? '0 : (id_src_used & {NSRC{id_valid}});
      end
   end

   // ---------------------------------------------------------------------------
   // Payload: tags and flags. Only meaningful while the matching valid bit is
   // set, so it is loaded unconditionally.
   // ---------------------------------------------------------------------------
   // NOTE: payload registers carry no reset; the valid bits above gate every
   // use, so resetting these would only add reset fan-out.
   always_ff @(posedge clk) begin
      for (int k = 1; k <= DEPTH; k++) begin
         slot_dst[k]  <= slot_dst[k-1];
         slot_wr[k]   <= slot_wr[k-1];
         slot_load[k] <= slot_load[k-1];
      end
      slot_dst[0]  <= id_dst;
      slot_wr[0]   <= id_wr;
      slot_load[0] <= id_load;
      ex_src       <= id_src;
   end

   // ---------------------------------------------------------------------------
   // Saturating stall-cycle counter; clear wins over increment.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (clr_cnt) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard_pipe.sv
// -----------------------------------------------------------------------------
// tb_fwd_scoreboard_pipe
//
// Directed bench for fwd_scoreboard_pipe. Three instances share one stimulus
// bundle: dut_a (defaults), dut_b (LOAD_STAGE=3) and dut_c (CNT_W=2). Each
// scenario task observes only the instance it targets.
// Inputs change 1 time unit after the rising edge; outputs are compared one
// further unit later.
// -----------------------------------------------------------------------------
module tb_fwd_scoreboard_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [2:0]  id_dst;
   logic        id_wr;
   logic        id_load;
   logic [5:0]  id_src;
   logic [1:0]  id_src_used;
   logic        flush;
   logic        clr_cnt;

   logic [3:0]  fwd_a, fwd_b, fwd_c;
   logic        stall_a, stall_b, stall_c;
   logic [15:0] cnt_a, cnt_b;
   logic [1:0]  cnt_c;

   int vectors     = 0;
   int miscompares = 0;

   localparam logic [3:0] ALU_EXP [4] = '{4'b0101, 4'b1010, 4'b1111, 4'b0000};
   localparam logic [1:0] SAT_EXP [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   always #5 clk = ~clk;

   fwd_scoreboard_pipe dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_dst(id_dst),
      .id_wr(id_wr), .id_load(id_load), .id_src(id_src),
      .id_src_used(id_src_used), .flush(flush), .fwd_sel(fwd_a),
      .stall(stall_a), .stall_cnt(cnt_a), .clr_cnt(clr_cnt)
   );

   fwd_scoreboard_pipe #(.LOAD_STAGE(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_dst(id_dst),
      .id_wr(id_wr), .id_load(id_load), .id_src(id_src),
      .id_src_used(id_src_used), .flush(flush), .fwd_sel(fwd_b),
      .stall(stall_b), .stall_cnt(cnt_b), .clr_cnt(clr_cnt)
   );

   fwd_scoreboard_pipe #(.CNT_W(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_dst(id_dst),
      .id_wr(id_wr), .id_load(id_load), .id_src(id_src),
      .id_src_used(id_src_used), .flush(flush), .fwd_sel(fwd_c),
      .stall(stall_c), .stall_cnt(cnt_c), .clr_cnt(clr_cnt)
   );

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [2:0] dst, input logic wr,
                         input logic ld, input logic [2:0] s1,
                         input logic [2:0] s0, input logic [1:0] used);
      id_valid    = v;
      id_dst      = dst;
      id_wr       = wr;
      id_load     = ld;
      id_src      = {s1, s0};
      id_src_used = used;
   endtask

   task automatic nop();
      set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
   endtask

   task automatic drain();
      nop();
      flush   = 1'b0;
      clr_cnt = 1'b0;
      repeat (4) step();
   endtask

   task automatic clear_counts();
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      nop();
      flush   = 1'b0;
      clr_cnt = 1'b0;
      #12;
      vectors++;
      if (stall_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_stall: got %b want 0", stall_a);
      end
      vectors++;
      if (fwd_a !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_fwd: got %b want 0000", fwd_a);
      end
      vectors++;
      if (cnt_a !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_cnt: got %0d want 0", cnt_a);
      end
      rst_n = 1'b1;
      step();

      // Build up a live stall in dut_b, then pull reset between edges.
      set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);   // LD R2
      step();
      set_id(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 3'd2, 2'b01);   // ADD R1 <- R2
      #1;
      vectors++;
      if (stall_a !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_stall_a: got %b want 1", stall_a);
      end
      step();
      vectors++;
      if (stall_b !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_stall_b: got %b want 1", stall_b);
      end
      vectors++;
      if (cnt_b !== 16'd1) begin
         miscompares++;
         $display("FAIL pre_reset_cnt_b: got %0d want 1", cnt_b);
      end

      rst_n = 1'b0;
      #1;
      vectors++;
      if (stall_b !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset_stall: got %b want 0", stall_b);
      end
      vectors++;
      if (cnt_b !== 16'd0 || cnt_a !== 16'd0) begin
         miscompares++;
         $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", cnt_a, cnt_b);
      end
      vectors++;
      if (fwd_a !== 4'b0000 || fwd_b !== 4'b0000) begin
         miscompares++;
         $display("FAIL async_reset_fwd: got %b/%b want 0000", fwd_a, fwd_b);
      end
      nop();
      #1;
      rst_n = 1'b1;
   endtask

   // ADD R3 followed by SUB R3,R3 with 0..3 NOPs in between.
   task automatic test_alu_chain();
      for (int g = 0; g < 4; g++) begin
         drain();
         set_id(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);   // ADD R3
         step();
         for (int n = 0; n < g; n++) begin
            nop();
            step();
         end
         set_id(1'b1, 3'd5, 1'b1, 1'b0, 3'd3, 3'd3, 2'b11);   // SUB R5 <- R3,R3
         #1;
         vectors++;
         if (stall_a !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_gap%0d_stall: got %b want 0", g, stall_a);
         end
         step();
         vectors++;
         if (fwd_a !== ALU_EXP[g]) begin
            miscompares++;
            $display("FAIL alu_gap%0d_fwd: got %b want %b", g, fwd_a, ALU_EXP[g]);
         end
      end
   endtask

   task automatic test_load_use();
      drain();
      clear_counts();
      set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);      // LD R2
      step();
      set_id(1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 3'd2, 2'b01);      // ADD R6 <- R2
      #1;
      vectors++;
      if (stall_a !== 1'b1) begin
         miscompares++;
         $display("FAIL ld_use_stall: got %b want 1", stall_a);
      end
      step();
      vectors++;
      if (stall_a !== 1'b0) begin
         miscompares++;
         $display("FAIL ld_use_release: got %b want 0", stall_a);
      end
      vectors++;
      if (cnt_a !== 16'd1) begin
         miscompares++;
         $display("FAIL ld_use_cnt: got %0d want 1", cnt_a);
      end
      step();
      vectors++;
      if (fwd_a !== 4'b0010) begin
         miscompares++;
         $display("FAIL ld_use_fwd: got %b want 0010", fwd_a);
      end
      vectors++;
      if (dut_a.early_load_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL ld_use_early_hit: got %b want 0", dut_a.early_load_hit);
      end
   endtask

   task automatic test_load_stage3();
      drain();
      clear_counts();
      set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);      // LD R2
      step();
      set_id(1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 3'd2, 2'b01);      // ADD R6 <- R2
      #1;
      vectors++;
      if (stall_b !== 1'b1) begin
         miscompares++;
         $display("FAIL ls3_stall1: got %b want 1", stall_b);
      end
      step();
      vectors++;
      if (stall_b !== 1'b1) begin
         miscompares++;
         $display("FAIL ls3_stall2: got %b want 1", stall_b);
      end
      step();
      vectors++;
      if (stall_b !== 1'b0) begin
         miscompares++;
         $display("FAIL ls3_release: got %b want 0", stall_b);
      end
      vectors++;
      if (cnt_b !== 16'd2) begin
         miscompares++;
         $display("FAIL ls3_cnt: got %0d want 2", cnt_b);
      end
      step();
      vectors++;
      if (fwd_b !== 4'b0011) begin
         miscompares++;
         $display("FAIL ls3_fwd: got %b want 0011", fwd_b);
      end
      vectors++;
      if (dut_b.early_load_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL ls3_early_hit: got %b want 0", dut_b.early_load_hit);
      end
   endtask

   // LD R4, ADDI R4 <- R1, ST reading R4 twice: the ADDI shadows the load.
   task automatic test_youngest();
      drain();
      set_id(1'b1, 3'd4, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);      // LD R4
      step();
      set_id(1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 3'd1, 2'b01);      // ADDI R4 <- R1
      #1;
      vectors++;
      if (stall_a !== 1'b0) begin
         miscompares++;
         $display("FAIL young_addi_stall: got %b want 0", stall_a);
      end
      step();
      set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd4, 3'd4, 2'b11);      // ST [R4] <- R4
      #1;
      vectors++;
      if (stall_a !== 1'b0) begin
         miscompares++;
         $display("FAIL young_st_stall: got %b want 0", stall_a);
      end
      step();
      vectors++;
      if (fwd_a !== 4'b0101) begin
         miscompares++;
         $display("FAIL young_fwd: got %b want 0101", fwd_a);
      end
   endtask

   task automatic test_flush();
      drain();
      clear_counts();
      set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);      // LD R2
      step();
      set_id(1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 3'd2, 2'b01);      // ADD R6 <- R2
      flush = 1'b1;
      #1;
      vectors++;
      if (stall_a !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_stall: got %b want 0", stall_a);
      end
      step();
      flush = 1'b0;
      set_id(1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 3'd6, 2'b01);      // SUB R7 <- R6
      #1;
      vectors++;
      if (stall_a !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_next_stall: got %b want 0", stall_a);
      end
      step();
      vectors++;
      if (fwd_a !== 4'b0000) begin
         miscompares++;
         $display("FAIL flush_squashed_fwd: got %b want 0000", fwd_a);
      end
      vectors++;
      if (cnt_a !== 16'd0) begin
         miscompares++;
         $display("FAIL flush_cnt: got %0d want 0", cnt_a);
      end
   endtask

   task automatic test_unused();
      drain();
      set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);      // LD R2
      step();
      set_id(1'b1, 3'd2, 1'b1, 1'b0, 3'd2, 3'd2, 2'b00);      // LBI R2
      #1;
      vectors++;
      if (stall_a !== 1'b0) begin
         miscompares++;
         $display("FAIL unused_lbi_stall: got %b want 0", stall_a);
      end
      step();
      set_id(1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 3'd2, 2'b00);      // J
      #1;
      vectors++;
      if (stall_a !== 1'b0 || fwd_a !== 4'b0000) begin
         miscompares++;
         $display("FAIL unused_j: got stall=%b fwd=%b want 0/0000", stall_a, fwd_a);
      end
      step();
      vectors++;
      if (fwd_a !== 4'b0000) begin
         miscompares++;
         $display("FAIL unused_j_fwd: got %b want 0000", fwd_a);
      end
   endtask

   task automatic test_saturation();
      drain();
      clear_counts();
      for (int n = 0; n < 5; n++) begin
         set_id(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);   // LD R2
         step();
         set_id(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 3'd2, 2'b01);   // ADD R1 <- R2
         step();
         step();
         vectors++;
         if (cnt_c !== SAT_EXP[n]) begin
            miscompares++;
            $display("FAIL sat_cnt%0d: got %0d want %0d", n, cnt_c, SAT_EXP[n]);
         end
      end
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      vectors++;
      if (cnt_c !== 2'd0) begin
         miscompares++;
         $display("FAIL sat_clear: got %0d want 0", cnt_c);
      end
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_load_use();
      test_load_stage3();
      test_youngest();
      test_flush();
      test_unused();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
